// File: rtl/te_fifo_if.sv
// Handshake bundle between the tracking-engine reader and the sample FIFO.
// master = TE reader side, slave = FIFO side.
interface te_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_ready;
    logic                  fifo_data_valid;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_last_data;
    logic                  fifo_read;
    logic                  fifo_rewind;
    logic                  fifo_skip;

    modport master (
        input  fifo_ready, fifo_data_valid, fifo_data, fifo_last_data,
        output fifo_read, fifo_rewind, fifo_skip
    );

    modport slave (
        output fifo_ready, fifo_data_valid, fifo_data, fifo_last_data,
        input  fifo_read, fifo_rewind, fifo_skip
    );
endinterface

// File: rtl/te_fifo_reader.sv
// Consumer-side sequencer for the TE sample FIFO: requests a block, replays it
// once per correlator pass via rewind, releases it with skip after the last pass.
module te_fifo_reader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 14,
    parameter int PASS_WIDTH    = 4,
    parameter int TIMEOUT_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PASS_WIDTH-1:0] pass_count,
    input  logic [ADDR_WIDTH-1:0] block_size,
    input  logic                  err_clear,
    te_fifo_if.master             fifo,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_first,
    output logic                  out_last,
    output logic [PASS_WIDTH-1:0] pass_index,
    output logic                  block_done,
    output logic [15:0]           block_count,
    output logic                  err_length,
    output logic                  err_timeout,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_RECV   = 3'd2,
        S_POST   = 3'd3,
        S_WAIT1  = 3'd4,
        S_WAIT2A = 3'd5,
        S_WAIT2B = 3'd6
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    beat_cnt_q;
    logic [TIMEOUT_WIDTH-1:0] wdog_q;
    logic [PASS_WIDTH-1:0]    pass_index_q;
    logic [15:0]              block_count_q;
    logic                     first_pend_q;
    logic                     err_length_q, err_timeout_q, busy_q;
    logic                     out_valid_q, out_first_q, out_last_q;
    logic [DATA_WIDTH-1:0]    out_data_q;

    logic                     in_recv_s, pass_end_s, wdog_sat_s, last_pass_s;
    logic                     len_err_s, beat_in_s;
    logic [ADDR_WIDTH:0]      beat_inc_s;
    logic [PASS_WIDTH-1:0]    last_idx_s;
    logic                     read_s, rewind_s, skip_s;

    // Pass-end, watchdog and last-pass conditions derived from registered state.
    always_comb begin
        in_recv_s   = (state_q == S_RECV);
        beat_in_s   = in_recv_s && fifo.fifo_data_valid;
        beat_inc_s  = {1'b0, beat_cnt_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
        pass_end_s  = in_recv_s && (fifo.fifo_last_data ||
                      (fifo.fifo_data_valid && (beat_inc_s == {1'b0, block_size})));
        wdog_sat_s  = in_recv_s && !pass_end_s && (wdog_q == {TIMEOUT_WIDTH{1'b1}});
        last_idx_s  = (pass_count == {PASS_WIDTH{1'b0}}) ? {PASS_WIDTH{1'b0}}
                                                         : pass_count - {{(PASS_WIDTH-1){1'b0}}, 1'b1};
        last_pass_s = (pass_index_q == last_idx_s);
        // Beats outside RECV are dropped and count as a length violation.
        len_err_s   = (in_recv_s && fifo.fifo_last_data && (beat_inc_s != {1'b0, block_size})) ||
                      (!in_recv_s && fifo.fifo_data_valid);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable && fifo.fifo_ready) state_d = S_REQ; else state_d = S_IDLE;
            S_REQ:    state_d = S_RECV;
            S_RECV:   if (pass_end_s) state_d = S_POST;
                      else if (wdog_sat_s) state_d = S_IDLE;
                      else state_d = S_RECV;
            S_POST:   if (last_pass_s) state_d = S_WAIT2A;
                      else if (enable) state_d = S_WAIT1;
                      else state_d = S_IDLE;
            S_WAIT1:  if (enable) state_d = S_REQ; else state_d = S_IDLE;
            S_WAIT2A: state_d = S_WAIT2B;
            S_WAIT2B: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Handshake pulses decoded from state; suppressed while reset is applied.
    always_comb begin
        read_s   = 1'b0;
        rewind_s = 1'b0;
        skip_s   = 1'b0;
        if (!rst) begin
            read_s   = (state_q == S_REQ);
            rewind_s = wdog_sat_s || ((state_q == S_POST) && !last_pass_s);
            skip_s   = (state_q == S_POST) && last_pass_s;
        end else begin
            read_s   = 1'b0;
            rewind_s = 1'b0;
            skip_s   = 1'b0;
        end
    end

    // Beat counter, watchdog, pass index and block counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q    <= {ADDR_WIDTH{1'b0}};
            wdog_q        <= {TIMEOUT_WIDTH{1'b0}};
            pass_index_q  <= {PASS_WIDTH{1'b0}};
            block_count_q <= 16'd0;
            first_pend_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            case (state_q)
                S_REQ: begin
                    beat_cnt_q   <= {ADDR_WIDTH{1'b0}};
                    wdog_q       <= {TIMEOUT_WIDTH{1'b0}};
                    first_pend_q <= 1'b1;
                end
                S_RECV: begin
                    if (wdog_q != {TIMEOUT_WIDTH{1'b1}}) wdog_q <= wdog_q + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
                    if (fifo.fifo_data_valid) begin
                        first_pend_q <= 1'b0;
                        if (beat_cnt_q != {ADDR_WIDTH{1'b1}}) beat_cnt_q <= beat_inc_s[ADDR_WIDTH-1:0];
                    end
                end
                S_POST: begin
                    if (last_pass_s) begin
                        pass_index_q  <= {PASS_WIDTH{1'b0}};
                        block_count_q <= block_count_q + 16'd1;
                    end else if (enable) begin
                        pass_index_q  <= pass_index_q + {{(PASS_WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        pass_index_q  <= {PASS_WIDTH{1'b0}};
                    end
                end
                // Dropping enable before the re-request restarts the block at pass 0.
                S_WAIT1: if (!enable) pass_index_q <= {PASS_WIDTH{1'b0}};
                default: begin
                end
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as err_clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_length_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            if (len_err_s) err_length_q <= 1'b1;
            else if (err_clear) err_length_q <= 1'b0;
            if (wdog_sat_s) err_timeout_q <= 1'b1;
            else if (err_clear) err_timeout_q <= 1'b0;
        end
    end

    // Output sample register, one cycle behind the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_WIDTH{1'b0}};
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= beat_in_s;
            out_first_q <= beat_in_s && first_pend_q;
            out_last_q  <= in_recv_s && fifo.fifo_last_data;
            if (beat_in_s) out_data_q <= fifo.fifo_data;
        end
    end

    assign fifo.fifo_read   = read_s;
    assign fifo.fifo_rewind = rewind_s;
    assign fifo.fifo_skip   = skip_s;
    assign block_done       = skip_s;
    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign out_first        = out_first_q;
    assign out_last         = out_last_q;
    assign pass_index       = pass_index_q;
    assign block_count      = block_count_q;
    assign err_length       = err_length_q;
    assign err_timeout      = err_timeout_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_te_fifo_reader.sv
// Directed bench for te_fifo_reader: the bench plays the FIFO, a scoreboard
// holds expected output beats and a negedge monitor checks them and the handshake.
module tb_te_fifo_reader;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  pass_count;
    logic [13:0] block_size;
    logic        err_clear;
    logic        out_valid, out_first, out_last, block_done, err_length, err_timeout, busy;
    logic [7:0]  out_data;
    logic [3:0]  pass_index;
    logic [15:0] block_count;

    te_fifo_if #(.DATA_WIDTH(8)) fif ();

    te_fifo_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(14), .PASS_WIDTH(4), .TIMEOUT_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pass_count(pass_count),
        .block_size(block_size), .err_clear(err_clear), .fifo(fif),
        .out_valid(out_valid), .out_data(out_data), .out_first(out_first),
        .out_last(out_last), .pass_index(pass_index), .block_done(block_done),
        .block_count(block_count), .err_length(err_length),
        .err_timeout(err_timeout), .busy(busy)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        logic       l;
        logic [3:0] p;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_read = 0, n_rewind = 0, n_skip = 0;
    int   cyc = 0, rew_cyc = 0;
    bit   rew_pend = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_read(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (fif.fifo_read) seen = 1'b1;
            else tick();
        end
        chk(tag, seen, 1);
    endtask

    // which: 0 = skip, 1 = rewind
    task automatic wait_evt(input string tag, input int which, input int limit);
        int  base;
        bit  seen;
        base = (which == 0) ? n_skip : n_rewind;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (((which == 0) ? n_skip : n_rewind) > base) seen = 1'b1;
        end
        chk(tag, seen, 1);
    endtask

    task automatic send_pass(input int n, input bit with_last, input logic [3:0] pidx);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            fif.fifo_data       = 8'($urandom);
            fif.fifo_data_valid = 1'b1;
            fif.fifo_last_data  = with_last && (b == n - 1);
            e.d = fif.fifo_data;
            e.f = (b == 0);
            e.l = fif.fifo_last_data;
            e.p = pidx;
            sb_q.push_back(e);
            tick();
        end
        fif.fifo_data_valid = 1'b0;
        fif.fifo_last_data  = 1'b0;
    endtask

    // Output-beat scoreboard and handshake monitor.
    always @(negedge clk) begin
        cyc++;
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                chk("beat", {out_data, out_first, out_last, pass_index}, mon_e);
            end
        end
        if (fif.fifo_read || fif.fifo_rewind || fif.fifo_skip || block_done) begin
            chk("hs_onehot", $countones({fif.fifo_read, fif.fifo_rewind, fif.fifo_skip}), 1);
            chk("done_with_skip", block_done, fif.fifo_skip);
        end
        if (fif.fifo_read) begin
            n_read++;
            if (rew_pend) chk("rewind_read_gap", (cyc - rew_cyc) >= 2, 1);
            rew_pend = 1'b0;
        end
        if (fif.fifo_rewind) begin
            n_rewind++;
            rew_cyc  = cyc;
            rew_pend = 1'b1;
        end
        if (fif.fifo_skip) n_skip++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int r0, w0, s0;
        rst = 1'b1; enable = 1'b0; pass_count = 4'd1; block_size = 14'd16; err_clear = 1'b0;
        fif.fifo_ready = 1'b0; fif.fifo_data_valid = 1'b0; fif.fifo_data = 8'd0; fif.fifo_last_data = 1'b0;
        repeat (3) tick();
        chk("rst_outs_a", {out_valid, out_data, out_first, out_last, pass_index, block_done}, 64'd0);
        chk("rst_outs_b", {block_count, err_length, err_timeout, busy,
                           fif.fifo_read, fif.fifo_rewind, fif.fifo_skip}, 64'd0);
        rst = 1'b0;
        tick();

        // Single-pass block of 16 beats.
        enable = 1'b1; fif.fifo_ready = 1'b1;
        wait_read("t1_read");
        fif.fifo_ready = 1'b0;
        tick();
        send_pass(16, 1'b1, 4'd0);
        wait_evt("t1_skip", 0, 20);
        chk("t1_block_count", block_count, 1);
        chk("t1_errs", {err_length, err_timeout}, 0);
        chk("t1_reads", n_read, 1);
        chk("t1_rewinds", n_rewind, 0);
        chk("t1_sb_empty", sb_q.size(), 0);
        repeat (4) tick();
        chk("t1_idle", busy, 0);

        // Three passes of 8 beats with no fifo_ready between passes.
        pass_count = 4'd3; block_size = 14'd8;
        r0 = n_read; w0 = n_rewind;
        fif.fifo_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            wait_read("t2_read");
            fif.fifo_ready = 1'b0;
            tick();
            send_pass(8, 1'b1, 4'(p));
        end
        wait_evt("t2_skip", 0, 20);
        chk("t2_reads", n_read - r0, 3);
        chk("t2_rewinds", n_rewind - w0, 2);
        chk("t2_pass_index", pass_index, 0);
        chk("t2_block_count", block_count, 2);
        chk("t2_sb_empty", sb_q.size(), 0);
        repeat (4) tick();

        // Short pass: 9 beats with last against block_size 10.
        pass_count = 4'd1; block_size = 14'd10;
        fif.fifo_ready = 1'b1;
        wait_read("t3_read");
        fif.fifo_ready = 1'b0;
        tick();
        send_pass(9, 1'b1, 4'd0);
        wait_evt("t3_skip", 0, 20);
        chk("t3_err_length", err_length, 1);
        chk("t3_err_timeout", err_timeout, 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("t3_err_cleared", err_length, 0);
        chk("t3_block_count", block_count, 3);
        repeat (4) tick();

        // Watchdog: read issued, no data ever arrives.
        s0 = n_skip; w0 = n_rewind;
        fif.fifo_ready = 1'b1;
        wait_read("t4_read");
        fif.fifo_ready = 1'b0;
        tick();
        wait_evt("t4_rewind", 1, 5000);
        chk("t4_err_timeout", err_timeout, 1);
        chk("t4_busy", busy, 0);
        chk("t4_block_count", block_count, 3);
        chk("t4_rewinds", n_rewind - w0, 1);
        chk("t4_skips", n_skip - s0, 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("t4_err_cleared", err_timeout, 0);

        // Enable dropped during pass 0 of a two-pass block.
        pass_count = 4'd2; block_size = 14'd8;
        s0 = n_skip;
        fif.fifo_ready = 1'b1;
        wait_read("t5_read0");
        fif.fifo_ready = 1'b0;
        enable = 1'b0;
        tick();
        send_pass(8, 1'b1, 4'd0);
        wait_evt("t5_abort_rewind", 1, 20);
        chk("t5_no_skip", n_skip - s0, 0);
        chk("t5_pass_index", pass_index, 0);
        chk("t5_busy", busy, 0);
        r0 = n_read;
        fif.fifo_ready = 1'b1;
        repeat (5) tick();
        chk("t5_no_read_disabled", n_read - r0, 0);
        enable = 1'b1;
        wait_read("t5_reread");
        chk("t5_restart_pass0", pass_index, 0);
        fif.fifo_ready = 1'b0;
        tick();
        send_pass(8, 1'b1, 4'd0);
        wait_read("t5_read1");
        tick();
        send_pass(8, 1'b1, 4'd1);
        wait_evt("t5_skip", 0, 20);
        chk("t5_block_count", block_count, 4);
        chk("t5_sb_empty", sb_q.size(), 0);
        repeat (4) tick();

        // Reset in the middle of a pass.
        pass_count = 4'd1; block_size = 14'd16;
        fif.fifo_ready = 1'b1;
        wait_read("t6_read");
        fif.fifo_ready = 1'b0;
        tick();
        send_pass(5, 1'b0, 4'd0);
        rst = 1'b1;
        tick();
        chk("t6_rst_outs_a", {out_valid, out_data, out_first, out_last, pass_index, block_done}, 64'd0);
        chk("t6_rst_outs_b", {block_count, err_length, err_timeout, busy,
                              fif.fifo_read, fif.fifo_rewind, fif.fifo_skip}, 64'd0);
        r0 = n_read; w0 = n_rewind; s0 = n_skip;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("t6_no_pulses", {16'(n_read - r0), 16'(n_rewind - w0), 16'(n_skip - s0)}, 64'd0);
        chk("t6_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
